// File: rtl/unified_mem_responder.sv
// Shared memory responder for the instruction-fetch and MEM-stage data initiators.
// One access at a time from an internal word RAM, fixed latency, per-port valid pulses plus pipeline stall.
module unified_mem_responder #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              stall
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } stateT;

   typedef enum logic {
      PORT_INSTR,
      PORT_DATA
   } portT;

   stateT             state;
   portT              grantPort;
   portT              lastGrant;
   logic [3:0]        cnt;
   logic              latchedWe;
   logic [IDX_W-1:0]  latchedIdx;
   logic [DATA_W-1:0] latchedWdata;
   logic              grantData;
   logic              commitWrite;

   logic [DATA_W-1:0] mem [DEPTH];

   // Upper address bits only alias into the RAM, so they are deliberately dropped.
   if (ADDR_W > IDX_W) begin : gAddrAlias
      logic unusedAddrBits;
      assign unusedAddrBits = ^{i_addr[ADDR_W-1:IDX_W], d_addr[ADDR_W-1:IDX_W]};
   end

   // On a tie the port that did not win last time is served, so data wins the first tie after reset.
   always_comb begin
      grantData = d_req && (!i_req || (lastGrant == PORT_INSTR));
   end

   assign commitWrite = !rst && (state == ACCESS) && (cnt == 4'd0) &&
                        (grantPort == PORT_DATA) && latchedWe;

   always_ff @(posedge clk) begin
      if (commitWrite) begin
         mem[latchedIdx] <= latchedWdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         i_valid      <= 1'b0;
         d_valid      <= 1'b0;
         i_rdata      <= '0;
         d_rdata      <= '0;
         lastGrant    <= PORT_INSTR;
         grantPort    <= PORT_INSTR;
         latchedWe    <= 1'b0;
         latchedIdx   <= '0;
         latchedWdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               i_valid <= 1'b0;
               d_valid <= 1'b0;
               if (i_req || d_req) begin
                  grantPort    <= grantData ? PORT_DATA : PORT_INSTR;
                  lastGrant    <= grantData ? PORT_DATA : PORT_INSTR;
                  latchedWe    <= grantData && d_we;
                  latchedIdx   <= grantData ? d_addr[IDX_W-1:0] : i_addr[IDX_W-1:0];
                  latchedWdata <= d_wdata;
                  cnt          <= 4'(LATENCY - 1);
                  state        <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  if (grantPort == PORT_DATA) begin
                     d_valid <= 1'b1;
                     d_rdata <= latchedWe ? latchedWdata : mem[latchedIdx];
                  end else begin
                     i_valid <= 1'b1;
                     i_rdata <= mem[latchedIdx];
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               i_valid <= 1'b0;
               d_valid <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign stall = (i_req & ~i_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_unified_mem_responder.sv
// Bench for unified_mem_responder: directed vector table, hand-written corner sequences,
// then randomized initiator traffic checked against a transaction-level memory model.
module tb_unified_mem_responder;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        iReq, dReq, dWe;
   logic [15:0] iAddr, dAddr, dWdata;
   logic [15:0] iRdata, dRdata;
   logic        iValid, dValid, stall;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst;
      logic        iReq;
      logic [15:0] iAddr;
      logic        dReq;
      logic        dWe;
      logic [15:0] dAddr;
      logic [15:0] dWdata;
      logic        eIV;
      logic        eDV;
      logic        eStall;
      logic [15:0] eIR;
      logic [15:0] eDR;
   } vecT;

   vecT table_q[$];

   unified_mem_responder #(
      .DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(iReq), .i_addr(iAddr), .i_rdata(iRdata), .i_valid(iValid),
      .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
      .d_rdata(dRdata), .d_valid(dValid), .stall(stall)
   );

   always #5 clk = ~clk;

   // Transaction-level model: an access granted at edge e completes at edge e+LAT;
   // the edge right after completion (response cycle) ignores requests.
   int          edgeNo     = 0;
   bit          mBusy      = 0;
   bit          mPortD     = 0;
   bit          mWe        = 0;
   int          mIdx       = 0;
   logic [15:0] mWdata     = '0;
   int          mDoneEdge  = 0;
   int          mBlockEdge = -1;
   bit          mLastD     = 0;
   logic [15:0] mMem   [1024];
   bit          mKnown [1024];
   bit          eIV = 0, eDV = 0, eIRk = 0, eDRk = 0;
   logic [15:0] eIR = '0, eDR = '0;

   always @(posedge clk) begin
      edgeNo++;
      if (rst) begin
         mBusy = 0; eIV = 0; eDV = 0; eIR = '0; eDR = '0;
         eIRk = 1; eDRk = 1; mLastD = 0; mBlockEdge = -1;
      end else begin
         eIV = 0;
         eDV = 0;
         if (mBusy) begin
            if (edgeNo == mDoneEdge) begin
               if (mPortD) begin
                  if (mWe) begin
                     mMem[mIdx] = mWdata; mKnown[mIdx] = 1;
                     eDR = mWdata; eDRk = 1;
                  end else begin
                     eDR = mMem[mIdx]; eDRk = mKnown[mIdx];
                  end
                  eDV = 1;
               end else begin
                  eIR = mMem[mIdx]; eIRk = mKnown[mIdx]; eIV = 1;
               end
               mBusy = 0;
               mBlockEdge = edgeNo + 1;
            end
         end else if (edgeNo != mBlockEdge && (iReq || dReq)) begin
            mPortD    = dReq && (!iReq || !mLastD);
            mLastD    = mPortD;
            mWe       = mPortD && dWe;
            mIdx      = mPortD ? (int'(dAddr) % 1024) : (int'(iAddr) % 1024);
            mWdata    = dWdata;
            mDoneEdge = edgeNo + LAT;
            mBusy     = 1;
         end
      end
   end

   function automatic vecT mkVec(logic r, logic ir, logic [15:0] ia, logic dr, logic we,
                                 logic [15:0] da, logic [15:0] wd, logic eiv, logic edv,
                                 logic est, logic [15:0] eir, logic [15:0] edr);
      vecT v;
      v.rst = r; v.iReq = ir; v.iAddr = ia; v.dReq = dr; v.dWe = we; v.dAddr = da;
      v.dWdata = wd; v.eIV = eiv; v.eDV = edv; v.eStall = est; v.eIR = eir; v.eDR = edr;
      return v;
   endfunction

   task automatic addRows(int n, vecT v);
      for (int k = 0; k < n; k++) table_q.push_back(v);
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(vecT v, string tag);
      check({tag, " i_valid"}, 32'(iValid), 32'(v.eIV));
      check({tag, " d_valid"}, 32'(dValid), 32'(v.eDV));
      check({tag, " stall"},   32'(stall),  32'(v.eStall));
      check({tag, " i_rdata"}, 32'(iRdata), 32'(v.eIR));
      check({tag, " d_rdata"}, 32'(dRdata), 32'(v.eDR));
   endtask

   task automatic applyStimulus(vecT v, string tag);
      rst = v.rst; iReq = v.iReq; iAddr = v.iAddr; dReq = v.dReq;
      dWe = v.dWe; dAddr = v.dAddr; dWdata = v.dWdata;
      #1;
      checkOutput(v, tag);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkModel(int n);
      string tag;
      tag = $sformatf("rand%0d", n);
      check({tag, " i_valid"}, 32'(iValid), 32'(eIV));
      check({tag, " d_valid"}, 32'(dValid), 32'(eDV));
      check({tag, " stall"}, 32'(stall), 32'((iReq && !eIV) || (dReq && !eDV)));
      if (eIRk) check({tag, " i_rdata"}, 32'(iRdata), 32'(eIR));
      if (eDRk) check({tag, " d_rdata"}, 32'(dRdata), 32'(eDR));
   endtask

   function automatic logic [15:0] randAddr();
      return 16'(($urandom_range(0, 63) << 10) | $urandom_range(0, 15));
   endfunction

   initial begin
      bit prevIV, prevDV;
      rst = 1; iReq = 0; dReq = 0; dWe = 0; iAddr = '0; dAddr = '0; dWdata = '0;
      @(posedge clk);
      @(negedge clk);

      // Reset with a pending instruction request, then quiet cycles proving nothing was started.
      addRows(2, mkVec(1, 1, 16'h0010, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000));
      addRows(6, mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
      // Data write 0xBEEF @0x10, then read it back.
      addRows(5, mkVec(0, 0, 0, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 1, 16'h0000, 16'h0000));
      addRows(1, mkVec(0, 0, 0, 1, 1, 16'h0010, 16'hBEEF, 0, 1, 0, 16'h0000, 16'hBEEF));
      addRows(5, mkVec(0, 0, 0, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 16'h0000, 16'hBEEF));
      addRows(1, mkVec(0, 0, 0, 1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'h0000, 16'hBEEF));
      addRows(1, mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'hBEEF));
      // Wrap: write 0x1234 @0x0405, fetch through the instruction port @0x0005.
      addRows(5, mkVec(0, 0, 0, 1, 1, 16'h0405, 16'h1234, 0, 0, 1, 16'h0000, 16'hBEEF));
      addRows(1, mkVec(0, 0, 0, 1, 1, 16'h0405, 16'h1234, 0, 1, 0, 16'h0000, 16'h1234));
      addRows(5, mkVec(0, 1, 16'h0005, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h1234));
      addRows(1, mkVec(0, 1, 16'h0005, 0, 0, 0, 0, 1, 0, 0, 16'h1234, 16'h1234));
      addRows(1, mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h1234));

      for (int r = 0; r < table_q.size(); r++) begin
         applyStimulus(table_q[r], $sformatf("vec%0d", r));
      end

      // Tie from reset: data first, instruction after; stall held until the instruction completes.
      applyStimulus(mkVec(1, 1, 16'h0005, 1, 0, 16'h0010, 0, 0, 0, 1, 16'h1234, 16'h1234), "tieRst0");
      applyStimulus(mkVec(1, 1, 16'h0005, 1, 0, 16'h0010, 0, 0, 0, 1, 16'h0000, 16'h0000), "tieRst1");
      for (int c = 0; c < 5; c++)
         applyStimulus(mkVec(0, 1, 16'h0005, 1, 0, 16'h0010, 0, 0, 0, 1, 16'h0000, 16'h0000),
                       $sformatf("tie%0d", c));
      applyStimulus(mkVec(0, 1, 16'h0005, 1, 0, 16'h0010, 0, 0, 1, 1, 16'h0000, 16'hBEEF), "tie5");
      for (int c = 6; c < 11; c++)
         applyStimulus(mkVec(0, 1, 16'h0005, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'hBEEF),
                       $sformatf("tie%0d", c));
      applyStimulus(mkVec(0, 1, 16'h0005, 0, 0, 0, 0, 1, 0, 0, 16'h1234, 16'hBEEF), "tie11");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 16'hBEEF), "tie12");

      // Reset in the middle of a write: 0x5555 stays, 0xAAAA is never committed.
      for (int c = 0; c < 5; c++)
         applyStimulus(mkVec(0, 0, 0, 1, 1, 16'h0020, 16'h5555, 0, 0, 1, 16'h1234, 16'hBEEF),
                       $sformatf("pre%0d", c));
      applyStimulus(mkVec(0, 0, 0, 1, 1, 16'h0020, 16'h5555, 0, 1, 0, 16'h1234, 16'h5555), "pre5");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h5555), "pre6");
      for (int c = 0; c < 2; c++)
         applyStimulus(mkVec(0, 0, 0, 1, 1, 16'h0020, 16'hAAAA, 0, 0, 1, 16'h1234, 16'h5555),
                       $sformatf("abort%0d", c));
      applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h5555), "abort2");
      for (int c = 3; c < 9; c++)
         applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000),
                       $sformatf("abort%0d", c));
      for (int c = 0; c < 5; c++)
         applyStimulus(mkVec(0, 0, 0, 1, 0, 16'h0020, 0, 0, 0, 1, 16'h0000, 16'h0000),
                       $sformatf("reread%0d", c));
      applyStimulus(mkVec(0, 0, 0, 1, 0, 16'h0020, 0, 0, 1, 0, 16'h0000, 16'h5555), "reread5");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h5555), "reread6");

      // Request dropped during the access: completion still pulses, stall falls with the request.
      for (int c = 0; c < 2; c++)
         applyStimulus(mkVec(0, 0, 0, 1, 0, 16'h0010, 0, 0, 0, 1, 16'h0000, 16'h5555),
                       $sformatf("drop%0d", c));
      for (int c = 2; c < 5; c++)
         applyStimulus(mkVec(0, 0, 0, 0, 0, 16'h0010, 0, 0, 0, 0, 16'h0000, 16'h5555),
                       $sformatf("drop%0d", c));
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'hBEEF), "drop5");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'hBEEF), "drop6");

      // Random initiators obeying the handshake, with occasional early drops and resets.
      prevIV = 0;
      prevDV = 0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 399) == 0);
         if (prevIV) iReq = 0;
         else if (!iReq) iReq = ($urandom_range(0, 3) == 0);
         else if ($urandom_range(0, 49) == 0) iReq = 0;
         if (prevDV) dReq = 0;
         else if (!dReq) dReq = ($urandom_range(0, 3) == 0);
         else if ($urandom_range(0, 49) == 0) dReq = 0;
         iAddr  = randAddr();
         dAddr  = randAddr();
         dWe    = 1'($urandom_range(0, 1));
         dWdata = 16'($urandom);
         #1;
         checkModel(n);
         prevIV = eIV;
         prevDV = eDV;
         @(posedge clk);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
